// File: rtl/tmnt_pkg.sv
// tmnt_pkg: shared key-state encoding and defaults for the pushbutton front end
package tmnt_pkg;
  typedef enum logic [1:0] {
    KEY_RELEASED,
    KEY_PRESS_PEND,
    KEY_PRESSED,
    KEY_RELEASE_PEND
  } key_state_t;
  localparam int NUM_KEYS_DEFAULT = 16;
endpackage

// File: rtl/pb_key_conditioner_debounce_cell.sv
// debounce_cell: two-flop synchroniser plus tick-sampled debounce FSM for one key
module debounce_cell
  import tmnt_pkg::*;
#(
  parameter int STABLE_SAMPLES = 4
) (
  input  logic hwclk,
  input  logic reset,
  input  logic tick,
  input  logic raw,
  output logic stable
);
  localparam int CW = $clog2(STABLE_SAMPLES + 1);
  localparam bit ONE = STABLE_SAMPLES == 1;
  localparam logic [CW-1:0] LAST = CW'(STABLE_SAMPLES - 1);
  logic s1, s;
  logic [CW-1:0] cnt, cnt_nx;
  key_state_t state, state_nx;
  always_ff @(posedge hwclk) begin
    if (reset) begin
      s1 <= 1'b0;
      s <= 1'b0;
      state <= KEY_RELEASED;
      cnt <= '0;
    end else begin
      s1 <= raw;
      s <= s1;
      state <= state_nx;
      cnt <= cnt_nx;
    end
  end
  // Pending states count agreeing samples; the first one is counted on entry.
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    if (tick)
      case (state)
        KEY_RELEASED: if (s) begin
          state_nx = ONE ? KEY_PRESSED : KEY_PRESS_PEND;
          cnt_nx = ONE ? '0 : CW'(1);
        end
        KEY_PRESS_PEND: begin
          state_nx = !s ? KEY_RELEASED : (cnt == LAST) ? KEY_PRESSED : KEY_PRESS_PEND;
          cnt_nx = (!s || cnt == LAST) ? '0 : cnt + 1'b1;
        end
        KEY_PRESSED: if (!s) begin
          state_nx = ONE ? KEY_RELEASED : KEY_RELEASE_PEND;
          cnt_nx = ONE ? '0 : CW'(1);
        end
        KEY_RELEASE_PEND: begin
          state_nx = s ? KEY_PRESSED : (cnt == LAST) ? KEY_RELEASED : KEY_RELEASE_PEND;
          cnt_nx = (s || cnt == LAST) ? '0 : cnt + 1'b1;
        end
      endcase
  end
  always_comb stable = (state == KEY_PRESSED) || (state == KEY_RELEASE_PEND);
endmodule

// File: rtl/pb_key_conditioner.sv
// pb_key_conditioner: debounces raw pushbuttons and encodes the highest held key
module pb_key_conditioner
  import tmnt_pkg::*;
#(
  parameter int NUM_KEYS = NUM_KEYS_DEFAULT,
  parameter int SAMPLE_DIV = 10000,
  parameter int STABLE_SAMPLES = 4
) (
  input  logic                        hwclk,
  input  logic                        reset,
  input  logic [NUM_KEYS-1:0]         pb,
  output logic [NUM_KEYS-1:0]         keys_stable,
  output logic                        key_valid,
  output logic [$clog2(NUM_KEYS)-1:0] key_index,
  output logic                        press_strobe,
  output logic                        release_strobe
);
  localparam int IW = $clog2(NUM_KEYS);
  localparam int DW = $clog2(SAMPLE_DIV);
  logic [DW-1:0] div;
  logic tick, enc_valid;
  logic [IW-1:0] enc_index;
  assign tick = div == DW'(SAMPLE_DIV - 1);
  always_ff @(posedge hwclk) begin
    if (reset) div <= '0;
    else div <= tick ? '0 : div + 1'b1;
  end
  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    debounce_cell #(.STABLE_SAMPLES(STABLE_SAMPLES)) u_cell (
      .hwclk(hwclk),
      .reset(reset),
      .tick(tick),
      .raw(pb[k]),
      .stable(keys_stable[k])
    );
  end
  always_comb begin
    enc_valid = 1'b0;
    enc_index = '0;
    for (int i = 0; i < NUM_KEYS; i++)
      if (keys_stable[i]) begin
        enc_valid = 1'b1;
        enc_index = IW'(i);
      end
  end
  // Strobes compare the outgoing registered value with the incoming one.
  always_ff @(posedge hwclk) begin
    if (reset) begin
      key_valid <= 1'b0;
      key_index <= '0;
      press_strobe <= 1'b0;
      release_strobe <= 1'b0;
    end else begin
      key_valid <= enc_valid;
      key_index <= enc_index;
      press_strobe <= enc_valid && (!key_valid || enc_index != key_index);
      release_strobe <= key_valid && !enc_valid;
    end
  end
endmodule

// File: tb/tb_pb_key_conditioner.sv
// tb_pb_key_conditioner: directed checks of debounce, encoding and strobes
module tb_pb_key_conditioner;
  logic hwclk = 1'b0, reset = 1'b1;
  logic [15:0] pb = '0;
  logic [15:0] keys_stable;
  logic key_valid, press_strobe, release_strobe;
  logic [3:0] key_index;
  int tests = 0, fails = 0, press_seen = 0, rel_seen = 0;

  pb_key_conditioner #(.NUM_KEYS(16), .SAMPLE_DIV(4), .STABLE_SAMPLES(3)) dut (
    .hwclk(hwclk),
    .reset(reset),
    .pb(pb),
    .keys_stable(keys_stable),
    .key_valid(key_valid),
    .key_index(key_index),
    .press_strobe(press_strobe),
    .release_strobe(release_strobe)
  );

  always #5 hwclk = ~hwclk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge hwclk);
      if (press_strobe === 1'b1) press_seen++;
      if (release_strobe === 1'b1) rel_seen++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    pb = 16'hFFFF;
    cyc(5);
    tests++;
    if (keys_stable !== 16'h0000) begin fails++; $display("FAIL reset_keys: got %h want 0000", keys_stable); end
    tests++;
    if ({key_valid, key_index, press_strobe, release_strobe} !== 7'd0) begin
      fails++; $display("FAIL reset_outs: valid=%b idx=%0d ps=%b rs=%b want all 0", key_valid, key_index, press_strobe, release_strobe);
    end
    reset = 1'b0;
    pb = '0;
    cyc(1);
    tests++;
    if (press_strobe !== 1'b0 || release_strobe !== 1'b0) begin
      fails++; $display("FAIL reset_first_cycle: ps=%b rs=%b want 0 0", press_strobe, release_strobe);
    end
    cyc(3);
  endtask

  task automatic test_single_press;
    int lat = 0;
    bit found = 0;
    pb = 16'h0020;
    for (int i = 1; i <= 20; i++) begin
      cyc(1);
      if (keys_stable === 16'h0020) begin lat = i; break; end
    end
    tests++;
    if (lat < 11 || lat > 14) begin fails++; $display("FAIL press_latency: got %0d cycles want 11..14", lat); end
    tests++;
    if (key_valid !== 1'b0) begin fails++; $display("FAIL press_valid_lag: got %b want 0", key_valid); end
    cyc(1);
    tests++;
    if (key_valid !== 1'b1 || key_index !== 4'd5 || press_strobe !== 1'b1) begin
      fails++; $display("FAIL press_k5: valid=%b idx=%0d ps=%b want 1 5 1", key_valid, key_index, press_strobe);
    end
    cyc(1);
    tests++;
    if (press_strobe !== 1'b0) begin fails++; $display("FAIL press_pulse_width: ps=%b want 0", press_strobe); end
    pb = '0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (release_strobe === 1'b1) begin found = 1; break; end
    end
    tests++;
    if (!found || key_valid !== 1'b0) begin fails++; $display("FAIL release_k5: seen=%b valid=%b want 1 0", found, key_valid); end
    cyc(1);
  endtask

  task automatic test_glitch;
    int bad = 0;
    int p0 = press_seen, r0 = rel_seen;
    for (int i = 0; i < 24; i++) begin
      pb = (i < 3) ? 16'h0200 : 16'h0000;
      cyc(1);
      if (keys_stable !== 16'h0000) bad++;
    end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL glitch_keys: %0d cycles nonzero want 0", bad); end
    tests++;
    if (press_seen != p0 || rel_seen != r0) begin
      fails++; $display("FAIL glitch_strobes: press=%0d release=%0d want 0 0", press_seen - p0, rel_seen - r0);
    end
  endtask

  task automatic test_two_keys;
    bit found = 0;
    int p0 = press_seen, r0;
    pb = 16'h0804;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (key_valid === 1'b1) begin found = 1; break; end
    end
    tests++;
    if (!found || key_index !== 4'd11 || press_strobe !== 1'b1) begin
      fails++; $display("FAIL two_press: seen=%b idx=%0d ps=%b want 1 11 1", found, key_index, press_strobe);
    end
    cyc(3);
    tests++;
    if (press_seen - p0 != 1) begin fails++; $display("FAIL two_single_strobe: got %0d strobes want 1", press_seen - p0); end
    r0 = rel_seen;
    found = 0;
    pb = 16'h0004;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (press_strobe === 1'b1) begin found = 1; break; end
    end
    tests++;
    if (!found || key_index !== 4'd2 || key_valid !== 1'b1 || rel_seen != r0) begin
      fails++; $display("FAIL drop_high: seen=%b idx=%0d valid=%b rel=%0d want 1 2 1 0", found, key_index, key_valid, rel_seen - r0);
    end
    found = 0;
    pb = '0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (release_strobe === 1'b1) begin found = 1; break; end
    end
    tests++;
    if (!found || key_valid !== 1'b0 || key_index !== 4'd0 || press_strobe !== 1'b0) begin
      fails++; $display("FAIL drop_all: seen=%b valid=%b idx=%0d ps=%b want 1 0 0 0", found, key_valid, key_index, press_strobe);
    end
    cyc(1);
  endtask

  task automatic test_reset_mid;
    bit found = 0;
    pb = 16'h0001;
    cyc(8);
    tests++;
    if (keys_stable !== 16'h0000) begin fails++; $display("FAIL mid_pending: got %h want 0000", keys_stable); end
    reset = 1'b1;
    cyc(1);
    tests++;
    if (keys_stable !== 16'h0000 || {key_valid, key_index, press_strobe, release_strobe} !== 7'd0) begin
      fails++; $display("FAIL mid_reset_outs: keys=%h valid=%b idx=%0d ps=%b rs=%b want all 0", keys_stable, key_valid, key_index, press_strobe, release_strobe);
    end
    reset = 1'b0;
    cyc(1);
    tests++;
    if (press_strobe !== 1'b0 || release_strobe !== 1'b0) begin
      fails++; $display("FAIL mid_first_cycle: ps=%b rs=%b want 0 0", press_strobe, release_strobe);
    end
    cyc(10);
    tests++;
    if (keys_stable !== 16'h0000) begin fails++; $display("FAIL requal_early: got %h want 0000", keys_stable); end
    cyc(1);
    tests++;
    if (keys_stable !== 16'h0001) begin fails++; $display("FAIL requal_on_time: got %h want 0001", keys_stable); end
    cyc(1);
    tests++;
    if (key_valid !== 1'b1 || key_index !== 4'd0 || press_strobe !== 1'b1) begin
      fails++; $display("FAIL requal_k0: valid=%b idx=%0d ps=%b want 1 0 1", key_valid, key_index, press_strobe);
    end
    pb = '0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (release_strobe === 1'b1) begin found = 1; break; end
    end
    tests++;
    if (!found) begin fails++; $display("FAIL requal_release: no release strobe seen"); end
    cyc(1);
  endtask

  task automatic test_bounce;
    int p0;
    reset = 1'b1;
    pb = '0;
    cyc(1);
    reset = 1'b0;
    pb = 16'h0080;
    cyc(4);
    pb = 16'h0000;
    cyc(4);
    pb = 16'h0080;
    p0 = press_seen;
    cyc(11);
    tests++;
    if (keys_stable !== 16'h0000 || press_seen != p0) begin
      fails++; $display("FAIL bounce_early: keys=%h strobes=%0d want 0000 0", keys_stable, press_seen - p0);
    end
    cyc(1);
    tests++;
    if (keys_stable !== 16'h0080) begin fails++; $display("FAIL bounce_qualify: got %h want 0080", keys_stable); end
    cyc(1);
    tests++;
    if (key_valid !== 1'b1 || key_index !== 4'd7 || press_strobe !== 1'b1) begin
      fails++; $display("FAIL bounce_k7: valid=%b idx=%0d ps=%b want 1 7 1", key_valid, key_index, press_strobe);
    end
  endtask

  initial begin
    test_reset;
    test_single_press;
    test_glitch;
    test_two_keys;
    test_reset_mid;
    test_bounce;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end
endmodule
